serial_rx_b13: RTL and testbench
================================

Name: serial_rx_b13

Overview:
- Serial receiver for the byte-serial link driven by the b13 transmitter.
- Frame: start bit 0, eight data bits MSB first, stop bit 1. Idle line is 1. Each bit is held for BIT_PERIOD clocks.
- Recovers the byte, presents it through a ready/ack handshake, and flags framing and overrun errors.
- Sits on the host side of the link, with the transmitter's data_out wired to serial_in.

Parameters:
- BIT_PERIOD, 106: clocks per bit, matching the transmitter's counter (bit emitted when count > 104).
- CNT_W, 10: width of the bit-timing counter. Must satisfy 2^CNT_W > BIT_PERIOD.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- serial_in  in  1  asynchronous serial line, idle high.
- rx_data  out  8  last good received byte.
- rx_ready  out  1  rx_data holds an unacknowledged byte.
- rx_ack  in  1  consumer accepts rx_data; sampled only while rx_ready=1.
- frame_error  out  1  sticky: stop bit sampled as 0.
- overrun  out  1  sticky: good frame completed while rx_ready=1 and not acked.
- err_clr  in  1  clears frame_error and overrun.
- busy  out  1  high in any state other than R_IDLE.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - rx_data=0, rx_ready=0, frame_error=0, overrun=0, busy=0, state=R_IDLE.
  - Counter=0, shift register=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame with no error flagged.
- Input synchronization: serial_in passes through two flops to give s_in, plus one history flop s_prev.
  - Fall = s_prev & ~s_in.
  - Latency from serial_in to s_in is 2 clocks.
- Counter rule: cnt clears to 0 on every state entry and after every sample, otherwise increments. A "sample" occurs on the cycle cnt == LIMIT-1.
- States and transitions:
  - R_IDLE: on fall, go to R_START (LIMIT = BIT_PERIOD/2, integer division).
  - R_START: at sample, if s_in=0 go to R_DATA with bit index=0; if s_in=1 (glitch) return to R_IDLE silently.
  - R_DATA (LIMIT = BIT_PERIOD): at each sample, shift = {shift[6:0], s_in} and increment index. After the sample with index=7, go to R_STOP.
  - R_STOP (LIMIT = BIT_PERIOD): at sample:
    - If s_in=1 (good frame), go to R_IDLE.
    - If s_in=0, set frame_error=1, discard the byte, go to R_BREAK.
  - R_BREAK: stay until s_in=1, then go to R_IDLE. A line held low never produces a new frame.
- Good-frame completion (the cycle after the stop sample):
  - If rx_ready=0, or rx_ack=1 in the same cycle: rx_data <= shift and rx_ready <= 1.
  - Otherwise: overrun <= 1, rx_data is unchanged (the first byte is kept), and the new byte is dropped.
- Handshake: rx_ready=1 & rx_ack=1 clears rx_ready on the next edge, unless a good frame completes in that same cycle (rule above). rx_ack while rx_ready=0 is ignored.
- err_clr=1 clears both sticky flags on the next edge. If an error event occurs in the same cycle as err_clr, the event wins and the flag stays 1.
- busy = (state != R_IDLE).
- Arithmetic: the counter saturates nowhere. It never exceeds BIT_PERIOD-1 by construction and wraps only through the explicit clear.

Decomposition:
- Shared package b13_pkg holds:
  - the state encodings R_IDLE=3'd0, R_START=3'd1, R_DATA=3'd2, R_STOP=3'd3, R_BREAK=3'd4;
  - the frame constants START_LVL=0, STOP_LVL=1, DATA_BITS=8;
  - the default BIT_PERIOD=106, shared with the transmitter.
- One sub-module, serial_sync: the 2-flop synchronizer plus history flop. Outputs s_in and fall; reset presets all flops to 1.

Test Plan:
- Frame 0xA5 with BIT_PERIOD=16, no ack -> rx_data=0xA5 and rx_ready=1 exactly 2+8+8*16+16+1 clocks after the serial_in falling edge; errors stay 0; rx_ready holds until rx_ack.
- Line low for 3 clocks then high -> state returns to R_IDLE, rx_ready=0, no errors, busy pulses for less than 10 clocks.
- Frame 0x3C with stop bit 0 -> frame_error=1, rx_ready=0, rx_data unchanged; a following good frame is received only after the line returns high; err_clr -> frame_error=0.
- Frames 0x11 then 0x22 without ack -> rx_data=0x11, overrun=1. Same sequence with rx_ack asserted on the completion cycle of 0x22 -> rx_data=0x22, rx_ready=1, overrun=0.
- reset_n=0 for 1 clock during data bit 4 of 0xFF -> all outputs at reset values next cycle; the next full frame 0x81 is received correctly.
- BIT_PERIOD=106 back-to-back frames 0x00 and 0xFF with an ack after each -> both bytes received, no errors.

Source files
------------

// File: rtl/serial_rx_b13_pkg.sv
// Shared definitions for the b13 serial link: receiver state encodings and
// frame constants common to the transmitter and receiver.
package b13_pkg;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd3,
    R_BREAK = 3'd4
  } rx_state_t;

  localparam logic        START_LVL  = 1'b0;
  localparam logic        STOP_LVL   = 1'b1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_PERIOD = 106;

endpackage

// File: rtl/serial_rx_b13_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a history flop
// for falling-edge detection. All flops preset to the idle (high) level.
module serial_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic serial_in,
  output logic s_in,
  output logic fall
);

  logic meta;
  logic s_prev;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      s_in   <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      meta   <= serial_in;
      s_in   <= meta;
      s_prev <= s_in;
    end
  end

  assign fall = s_prev & ~s_in;

endmodule

// File: rtl/serial_rx_b13.sv
// Byte-serial receiver for the b13 link: start bit, 8 data bits MSB first,
// stop bit. Presents bytes via ready/ack and flags framing/overrun errors.
module serial_rx_b13 #(
  parameter int unsigned BIT_PERIOD = b13_pkg::BIT_PERIOD,
  parameter int unsigned CNT_W      = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       frame_error,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  import b13_pkg::*;

  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(BIT_PERIOD - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             frame_done, frame_done_nx;
  logic             ferr_evt;
  logic             s_in;
  logic             fall;

  serial_sync u_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .s_in      (s_in),
    .fall      (fall)
  );

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt + 1'b1;
    bit_idx_nx    = bit_idx;
    shift_nx      = shift;
    frame_done_nx = 1'b0;
    ferr_evt      = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_nx = '0;
        if (fall) state_nx = R_START;
      end
      R_START: begin
        if (cnt == HALF_LIM) begin
          cnt_nx = '0;
          if (s_in == START_LVL) begin
            state_nx   = R_DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (cnt == FULL_LIM) begin
          cnt_nx     = '0;
          shift_nx   = {shift[6:0], s_in};
          bit_idx_nx = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_nx = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == FULL_LIM) begin
          cnt_nx = '0;
          if (s_in == STOP_LVL) begin
            state_nx      = R_IDLE;
            frame_done_nx = 1'b1;
          end else begin
            state_nx = R_BREAK;
            ferr_evt = 1'b1;
          end
        end
      end
      R_BREAK: begin
        cnt_nx = '0;
        if (s_in == STOP_LVL) state_nx = R_IDLE;
      end
      default: begin
        state_nx = R_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Byte delivery runs one cycle after the stop sample, so the ready/ack
  // decision uses the handshake state of that completion cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= R_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_done  <= 1'b0;
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_idx_nx;
      shift      <= shift_nx;
      frame_done <= frame_done_nx;

      if (frame_done && (!rx_ready || rx_ack)) begin
        rx_data  <= shift;
        rx_ready <= 1'b1;
      end else if (rx_ready && rx_ack) begin
        rx_ready <= 1'b0;
      end

      if (ferr_evt)     frame_error <= 1'b1;
      else if (err_clr) frame_error <= 1'b0;

      if (frame_done && rx_ready && !rx_ack) overrun <= 1'b1;
      else if (err_clr)                      overrun <= 1'b0;
    end
  end

  assign busy = (state != R_IDLE);

endmodule

// File: tb/tb_serial_rx_b13.sv
// Self-checking bench for serial_rx_b13: a BIT_PERIOD=16 instance for the
// functional scenarios and a BIT_PERIOD=106 instance for back-to-back frames.
module tb_serial_rx_b13;

  localparam int BP_S = 16;
  localparam int BP_L = 106;
  localparam int LAT  = 2 + BP_S / 2 + 8 * BP_S + BP_S + 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] data16, data106;
  logic       rdy16, rdy106, fe16, fe106, ov16, ov106, busy16, busy106;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q16[$];
  logic [7:0] q106[$];

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned busy_cnt = 0;
  logic        rdy_d = 1'b0;

  always #5 clock = ~clock;

  serial_rx_b13 #(.BIT_PERIOD(BP_S), .CNT_W(10)) u16 (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in),
    .rx_data(data16), .rx_ready(rdy16), .rx_ack(rx_ack),
    .frame_error(fe16), .overrun(ov16), .err_clr(err_clr), .busy(busy16)
  );

  serial_rx_b13 #(.BIT_PERIOD(BP_L), .CNT_W(10)) u106 (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in),
    .rx_data(data106), .rx_ready(rdy106), .rx_ack(rx_ack),
    .frame_error(fe106), .overrun(ov106), .err_clr(err_clr), .busy(busy106)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rdy16 && !rdy_d) rise_cyc = cyc;
    rdy_d = rdy16;
    if (busy16) busy_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; drives one full frame clock by clock. ack_at >= 0
  // raises rx_ack for exactly the clock with that index into the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bp,
                            input int ack_at, output int unsigned t_start);
    int k;
    t_start = cyc;
    for (int i = 0; i < 10 * bp; i++) begin
      k = i / bp;
      if (k == 0)      serial_in = 1'b0;
      else if (k == 9) serial_in = stop;
      else             serial_in = b[8-k];
      if (ack_at >= 0) rx_ack = (i == ack_at);
      @(negedge clock);
    end
    if (ack_at >= 0) rx_ack = 1'b0;
  endtask

  task automatic wait_byte(input bit big, input int budget);
    int n = 0;
    logic [7:0] exp_b;
    logic [7:0] got;
    while (!(big ? rdy106 : rdy16) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!(big ? rdy106 : rdy16)) begin
      $display("FAIL wait_byte%0s timeout: rx_ready=0 required 1", big ? "_106" : "_16");
      errors++;
    end else if ((big ? q106.size() : q16.size()) == 0) begin
      $display("FAIL wait_byte%0s unexpected byte 0x%02h", big ? "_106" : "_16",
               big ? data106 : data16);
      errors++;
    end else begin
      exp_b = big ? q106.pop_front() : q16.pop_front();
      got   = big ? data106 : data16;
      if (got !== exp_b) begin
        $display("FAIL wait_byte%0s rx_data=0x%02h required 0x%02h",
                 big ? "_106" : "_16", got, exp_b);
        errors++;
      end
      rx_ack = 1'b1;
      @(negedge clock);
      rx_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({data16, rdy16, fe16, ov16, busy16} !== 12'h000) begin
      $display("FAIL reset_16 outputs=%03h required 000", {data16, rdy16, fe16, ov16, busy16});
      errors++;
    end
    checks++;
    if ({data106, rdy106, fe106, ov106, busy106} !== 12'h000) begin
      $display("FAIL reset_106 outputs=%03h required 000",
               {data106, rdy106, fe106, ov106, busy106});
      errors++;
    end
  endtask

  task automatic test_basic_frame();
    int unsigned t0;
    rise_cyc = 0;
    q16.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BP_S, -1, t0);
    // t0 + 1 is the first rising edge that samples the low start level
    checks++;
    if (rise_cyc - t0 - 1 !== LAT) begin
      $display("FAIL basic_latency clocks=%0d required %0d", rise_cyc - t0 - 1, LAT);
      errors++;
    end
    repeat (20) @(negedge clock);
    checks++;
    if ({rdy16, fe16, ov16} !== 3'b100) begin
      $display("FAIL basic_hold ready/fe/ov=%03b required 100", {rdy16, fe16, ov16});
      errors++;
    end
    wait_byte(1'b0, 50);
    checks++;
    if (rdy16 !== 1'b0) begin
      $display("FAIL basic_ack_clear rx_ready=%0b required 0", rdy16);
      errors++;
    end
  endtask

  task automatic test_glitch();
    busy_cnt = 0;
    serial_in = 1'b0;
    repeat (3) @(negedge clock);
    serial_in = 1'b1;
    repeat (30) @(negedge clock);
    checks++;
    if (busy_cnt == 0 || busy_cnt >= 10) begin
      $display("FAIL glitch_busy_len busy_clocks=%0d required 1..9", busy_cnt);
      errors++;
    end
    checks++;
    if ({busy16, rdy16, fe16, ov16} !== 4'b0000) begin
      $display("FAIL glitch_state busy/rdy/fe/ov=%04b required 0000",
               {busy16, rdy16, fe16, ov16});
      errors++;
    end
  endtask

  task automatic test_frame_error();
    int unsigned t0;
    send_frame(8'h3C, 1'b0, BP_S, -1, t0);
    repeat (40) @(negedge clock);
    checks++;
    if ({fe16, rdy16, busy16, data16} !== {3'b101, 8'hA5}) begin
      $display("FAIL ferr_state fe/rdy/busy=%03b data=0x%02h required 101 0xa5",
               {fe16, rdy16, busy16}, data16);
      errors++;
    end
    serial_in = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (busy16 !== 1'b0) begin
      $display("FAIL ferr_break_exit busy=%0b required 0", busy16);
      errors++;
    end
    q16.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BP_S, -1, t0);
    wait_byte(1'b0, 50);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    checks++;
    if (fe16 !== 1'b0) begin
      $display("FAIL ferr_clear frame_error=%0b required 0", fe16);
      errors++;
    end
  endtask

  task automatic test_overrun();
    int unsigned t0;
    q16.push_back(8'h11);
    send_frame(8'h11, 1'b1, BP_S, -1, t0);
    send_frame(8'h22, 1'b1, BP_S, -1, t0);
    checks++;
    if ({ov16, rdy16} !== 2'b11) begin
      $display("FAIL overrun_flag ov/rdy=%02b required 11", {ov16, rdy16});
      errors++;
    end
    wait_byte(1'b0, 50);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    checks++;
    if (ov16 !== 1'b0) begin
      $display("FAIL overrun_clear overrun=%0b required 0", ov16);
      errors++;
    end
    // 0x11 is consumed by the ack that coincides with 0x22 completing
    send_frame(8'h11, 1'b1, BP_S, -1, t0);
    q16.push_back(8'h22);
    send_frame(8'h22, 1'b1, BP_S, LAT, t0);
    checks++;
    if ({ov16, rdy16} !== 2'b01) begin
      $display("FAIL overrun_same_cycle_ack ov/rdy=%02b required 01", {ov16, rdy16});
      errors++;
    end
    wait_byte(1'b0, 50);
  endtask

  task automatic test_reset_mid_frame();
    int unsigned t0;
    fork
      send_frame(8'hFF, 1'b1, BP_S, -1, t0);
      begin
        repeat (5 * BP_S + 8) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if ({data16, rdy16, fe16, ov16, busy16} !== 12'h000) begin
          $display("FAIL midreset outputs=%03h required 000",
                   {data16, rdy16, fe16, ov16, busy16});
          errors++;
        end
      end
    join
    q16.push_back(8'h81);
    send_frame(8'h81, 1'b1, BP_S, -1, t0);
    wait_byte(1'b0, 50);
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    q106.delete();
    q106.push_back(8'h00);
    q106.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1, BP_L, -1, t0);
        send_frame(8'hFF, 1'b1, BP_L, -1, t0);
      end
      begin
        wait_byte(1'b1, 1500);
        wait_byte(1'b1, 1500);
      end
    join
    checks++;
    if ({fe106, ov106} !== 2'b00) begin
      $display("FAIL b2b_errors fe/ov=%02b required 00", {fe106, ov106});
      errors++;
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
